// File: rtl/video_clock_ctrl.sv
// video_clock_ctrl
//    Pixel-domain clock/reset manager sitting behind the rPLL pixel-clock
//    wrapper. PLOCK is synchronised into PCLK and must stay high for a
//    qualification interval. A synchronous reset is then held for RST_HOLD
//    cycles before the block enters RUN. Lock losses from RUN are counted.
//    NUM_CH programmable clock-enable strobes are derived from PCLK and
//    phase-aligned on the first RUN cycle.
//
// Ports
//    PCLK      in   pixel clock, all logic on rising edge
//    RESET     in   synchronous active-high reset
//    PLOCK     in   PLL lock flag (asynchronous to PCLK)
//    DIV       in   per-channel divisor, channel i at [i*DIV_W +: DIV_W]
//    PRESET    out  synchronous active-high reset to the pixel domain
//    READY     out  high while in RUN
//    PCE       out  per-channel single-cycle clock-enable strobes
//    LOSS_CNT  out  saturating count of lock losses from RUN
//    PLL_RST   out  PLL reset request (timeout feature only, else 0)
//
// Build option
//    VCC_LOCK_TIMEOUT_EN : when defined, a stuck WAIT_LOCK pulses PLL_RST for
//    RST_HOLD cycles every TIMEOUT cycles until lock is seen.

module video_clock_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LOCK_STABLE = 1024,
   parameter int unsigned RST_HOLD    = 16,
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned DIV_W       = 8,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned TIMEOUT     = 65536
) (
   input  logic                      PCLK,
   input  logic                      RESET,
   input  logic                      PLOCK,
   input  logic [NUM_CH*DIV_W-1:0]   DIV,
   output logic                      PRESET,
   output logic                      READY,
   output logic [NUM_CH-1:0]         PCE,
   output logic [CNT_W-1:0]          LOSS_CNT,
   output logic                      PLL_RST
);

   typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;

   localparam int unsigned QMAX = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
   localparam int unsigned QW   = $clog2(QMAX) + 1;

   state_t              state;
   state_t              state_nx;
   logic [QW-1:0]       qcnt;
   logic [QW-1:0]       qcnt_nx;
   logic                preset_nx;
   logic                ready_nx;
   logic [CNT_W-1:0]    loss_nx;

   logic [SYNC_STAGES-1:0] sync;
   logic                   lock_s;

   logic [DIV_W-1:0]    cnt  [NUM_CH];
   logic [DIV_W-1:0]    dlat [NUM_CH];

   // PLOCK synchroniser
   always_ff @(posedge PCLK) begin
      if (RESET) sync <= '0;
      else       sync <= {sync[SYNC_STAGES-2:0], PLOCK};
   end

   assign lock_s = sync[SYNC_STAGES-1];

   // state register; outputs are registered from the next state
   always_ff @(posedge PCLK) begin
      if (RESET) begin
         state    <= WAIT_LOCK;
         qcnt     <= '0;
         PRESET   <= 1'b1;
         READY    <= 1'b0;
         LOSS_CNT <= '0;
      end else begin
         state    <= state_nx;
         qcnt     <= qcnt_nx;
         PRESET   <= preset_nx;
         READY    <= ready_nx;
         LOSS_CNT <= loss_nx;
      end
   end

   // next-state logic; the shared qualification counter restarts on every
   // state change so STABLE and HOLD each count from zero
   always_comb begin
      state_nx = state;
      qcnt_nx  = qcnt;
      case (state)
         WAIT_LOCK: begin
            qcnt_nx = '0;
            if (lock_s) state_nx = STABLE;
         end
         STABLE: begin
            if (!lock_s) begin
               state_nx = WAIT_LOCK;
               qcnt_nx  = '0;
            end else if (qcnt == QW'(LOCK_STABLE - 1)) begin
               state_nx = HOLD;
               qcnt_nx  = '0;
            end else begin
               qcnt_nx  = qcnt + QW'(1);
            end
         end
         HOLD: begin
            if (!lock_s) begin
               state_nx = WAIT_LOCK;
               qcnt_nx  = '0;
            end else if (qcnt == QW'(RST_HOLD - 1)) begin
               state_nx = RUN;
               qcnt_nx  = '0;
            end else begin
               qcnt_nx  = qcnt + QW'(1);
            end
         end
         RUN: begin
            qcnt_nx = '0;
            if (!lock_s) state_nx = WAIT_LOCK;
         end
         default: begin
            state_nx = WAIT_LOCK;
            qcnt_nx  = '0;
         end
      endcase
   end

   // output logic
   always_comb begin
      preset_nx = (state_nx != RUN);
      ready_nx  = (state_nx == RUN);
      loss_nx   = LOSS_CNT;
      if (state == RUN && !lock_s && LOSS_CNT != '1)
         loss_nx = LOSS_CNT + CNT_W'(1);
   end

   // Clock-enable channels. The divisor is only sampled on the strobe cycle,
   // so a DIV change lands at the next period boundary. A divisor of 0 or 1
   // keeps the counter parked at 0, giving a strobe every cycle.
   always_ff @(posedge PCLK) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (RESET || PRESET) begin
            cnt[i]  <= '0;
            dlat[i] <= '0;
         end else if (cnt[i] == '0) begin
            dlat[i] <= DIV[i*DIV_W +: DIV_W];
            cnt[i]  <= (DIV[i*DIV_W +: DIV_W] > DIV_W'(1)) ? DIV_W'(1) : '0;
         end else if (cnt[i] == dlat[i] - DIV_W'(1)) begin
            cnt[i]  <= '0;
         end else begin
            cnt[i]  <= cnt[i] + DIV_W'(1);
         end
      end
   end

   always_comb begin
      PCE = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         PCE[i] = !PRESET && (cnt[i] == '0);
   end

`ifdef VCC_LOCK_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT) + 1;
   localparam int unsigned HW = $clog2(RST_HOLD + 1);

   logic [TW-1:0] to_cnt;
   logic [HW-1:0] pulse_cnt;

   // timeout only advances while WAIT_LOCK persists; any exit clears it
   always_ff @(posedge PCLK) begin
      if (RESET || state != WAIT_LOCK || state_nx != WAIT_LOCK) begin
         to_cnt    <= '0;
         pulse_cnt <= '0;
      end else if (to_cnt == TW'(TIMEOUT - 1)) begin
         to_cnt    <= '0;
         pulse_cnt <= HW'(RST_HOLD);
      end else begin
         to_cnt    <= to_cnt + TW'(1);
         if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - HW'(1);
      end
   end

   assign PLL_RST = (pulse_cnt != '0);
`else
   // TIMEOUT only matters with the timeout feature; keep it referenced
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign PLL_RST        = 1'b0;
`endif

endmodule
